// File: rtl/dec4_16_if.sv
// Decoder request/response bundle.
// The master drives en/sel; the slave returns the decoded line vector.
interface dec4_16_if;
  logic        en;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        out_valid;

  modport master (
    output en,
    output sel,
    input  out,
    input  out_valid
  );

  modport slave (
    input  en,
    input  sel,
    output out,
    output out_valid
  );
endinterface

// File: rtl/dec4_16.sv
// 4-to-16 line decoder built as a binary tree of 1-to-2 cells.
// Optional output register and selectable active level.
module dec1_2 (
  input  logic en_i,
  input  logic sel_i,
  output logic out0_o,
  output logic out1_o
);
  assign out0_o = en_i & ~sel_i;
  assign out1_o = en_i &  sel_i;
endmodule

module dec4_16 #(
  parameter bit OUT_REG     = 1'b1,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  dec4_16_if.slave bus
);
  localparam logic [15:0] IDLE =
    ACTIVE_HIGH ? 16'h0000 : 16'hFFFF;

  // Heap-ordered tree: node k feeds 2k/2k+1; leaves 16..31 are lines 0..15.
  logic [31:1] node;
  logic [15:0] out_d;

  assign node[1] = bus.en;

  for (genvar k = 1; k < 16; k++) begin : g_tree
    localparam int LVL = $clog2(k + 1) - 1;
    dec1_2 u_cell (
      .en_i   (node[k]),
      .sel_i  (bus.sel[3-LVL]),
      .out0_o (node[2*k]),
      .out1_o (node[2*k+1])
    );
  end

  assign out_d = ACTIVE_HIGH ? node[31:16] : ~node[31:16];

  if (OUT_REG) begin : g_reg
    logic [15:0] out_q;
    logic        vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= IDLE;
        vld_q <= 1'b0;
      end else begin
        out_q <= out_d;
        vld_q <= bus.en;
      end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst_n;

    assign bus.out       = out_d;
    assign bus.out_valid = bus.en;
  end
endmodule

// File: tb/tb_dec4_16.sv
// Directed bench for dec4_16: registered, combinational
// and active-low variants driven from one stimulus source.
module tb_dec4_16;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] sel;

  int n_cmp = 0;
  int n_err = 0;

  dec4_16_if if_reg ();
  dec4_16_if if_comb ();
  dec4_16_if if_low ();

  assign if_reg.en   = en;
  assign if_reg.sel  = sel;
  assign if_comb.en  = en;
  assign if_comb.sel = sel;
  assign if_low.en   = en;
  assign if_low.sel  = sel;

  dec4_16 #(.OUT_REG(1'b1), .ACTIVE_HIGH(1'b1)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_reg)
  );

  dec4_16 #(.OUT_REG(1'b0), .ACTIVE_HIGH(1'b1)) u_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_comb)
  );

  dec4_16 #(.OUT_REG(1'b1), .ACTIVE_HIGH(1'b0)) u_low (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic edge_chk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] one_hot;

    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 4'h0;
    #12;
    chk("rst_out",     if_reg.out, 16'h0000);
    chk("rst_vld",     {15'b0, if_reg.out_valid}, 16'h0000);
    chk("rst_low_out", if_low.out, 16'hFFFF);

    @(negedge clk);
    rst_n = 1'b1;

    // Disabled sweep: sel covers 0..15 twice
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      sel = i[3:0];
      #1;
      chk("dis_comb", if_comb.out, 16'h0000);
      edge_chk();
      chk("dis_out", if_reg.out, 16'h0000);
      chk("dis_vld", {15'b0, if_reg.out_valid}, 16'h0000);
      chk("dis_low", if_low.out, 16'hFFFF);
    end

    // Enabled sweep, one line per cycle
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en  = 1'b1;
      sel = i[3:0];
      one_hot = 16'h0001 << i;
      #1;
      chk("en_comb", if_comb.out, one_hot);
      chk("en_hold", if_reg.out,
          (i == 0) ? 16'h0000 : (16'h0001 << (i - 1)));
      edge_chk();
      chk("en_out", if_reg.out, one_hot);
      chk("en_vld", {15'b0, if_reg.out_valid}, 16'h0001);
      chk("en_pop", 16'($countones(if_reg.out)), 16'd1);
      chk("en_low", if_low.out, ~one_hot);
    end

    // sel glitching between edges must not reach the register
    @(negedge clk);
    sel = 4'h2;
    edge_chk();
    chk("glt_a", if_reg.out, 16'h0004);
    #1;
    sel = 4'h9;
    #1;
    chk("glt_comb9", if_comb.out, 16'h0200);
    chk("glt_b", if_reg.out, 16'h0004);
    #2;
    sel = 4'h2;
    edge_chk();
    chk("glt_c", if_reg.out, 16'h0004);
    chk("glt_vld", {15'b0, if_reg.out_valid}, 16'h0001);

    // Asynchronous reset between edges
    @(negedge clk);
    sel = 4'hF;
    edge_chk();
    chk("ar_pre", if_reg.out, 16'h8000);
    chk("ar_pre_low", if_low.out, 16'h7FFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out", if_reg.out, 16'h0000);
    chk("ar_vld", {15'b0, if_reg.out_valid}, 16'h0000);
    chk("ar_low", if_low.out, 16'hFFFF);
    chk("ar_comb", if_comb.out, 16'h8000);
    edge_chk();
    chk("ar_hold", if_reg.out, 16'h0000);
    chk("ar_hold_low", if_low.out, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_rel", if_reg.out, 16'h0000);
    edge_chk();
    chk("ar_post", if_reg.out, 16'h8000);
    chk("ar_post_vld", {15'b0, if_reg.out_valid}, 16'h0001);

    // Combinational variant, no clock edge involved
    @(negedge clk);
    sel = 4'h5;
    #1;
    chk("cmb_5", if_comb.out, 16'h0020);
    chk("cmb_5_vld", {15'b0, if_comb.out_valid}, 16'h0001);
    en = 1'b0;
    #1;
    chk("cmb_off", if_comb.out, 16'h0000);
    chk("cmb_off_vld", {15'b0, if_comb.out_valid}, 16'h0000);

    // Active-low variant
    @(negedge clk);
    en  = 1'b1;
    sel = 4'h3;
    edge_chk();
    chk("low_3", if_low.out, 16'hFFF7);
    chk("low_3_vld", {15'b0, if_low.out_valid}, 16'h0001);
    @(negedge clk);
    en = 1'b0;
    edge_chk();
    chk("low_off", if_low.out, 16'hFFFF);
    chk("low_off_vld", {15'b0, if_low.out_valid}, 16'h0000);
    chk("reg_off", if_reg.out, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dec4_16.md
DEC4_16 -- requirements
Module: dec4_16

Interface
REQ-001 Parameter OUT_REG, default 1, meaning 1 = registered outputs (one-cycle latency), 0 = combinational outputs.
REQ-002 Parameter ACTIVE_HIGH, default 1, meaning 1 = selected line driven 1, 0 = selected line driven 0 and all others 1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock, the block's only clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  decode enable; 0 forces all lines inactive.
REQ-007 sel  input  4  binary line index, 0..15.
REQ-008 out  output  16  decoded line vector, bit i corresponds to sel == i.
REQ-009 out_valid  output  1  1 when out reflects an enabled decode.

Function
REQ-010 Structure: dec1_2 stage on sel[3] SHALL gate two 3-to-8 halves; each half SHALL split on sel[2] through dec1_2 stages down to sel[0] (binary tree of dec1_2 cells).
REQ-011 dec1_2 cell: out0 = en & ~sel, out1 = en & sel; both 0 when en = 0.
REQ-012 Decode (ACTIVE_HIGH=1): en=1 -> out SHALL have exactly bit sel set; en=0 -> out = 16'h0000.
REQ-013 ACTIVE_HIGH=0: out SHALL be the bitwise inverse of the REQ-012 value (en=0 -> 16'hFFFF).
REQ-014 out_valid SHALL equal en, aligned with out.
REQ-015 OUT_REG=0: out and out_valid SHALL follow en/sel combinationally with no clock dependence; rst_n SHALL have no effect on the outputs.
REQ-016 OUT_REG=1: out and out_valid SHALL be captured on each rising clk edge from the en/sel values present before that edge, giving exactly one cycle of latency.
REQ-017 OUT_REG=1: en/sel changes between clock edges SHALL NOT affect out.
REQ-018 Every sel value 0..15 SHALL be legal; no state other than the output register.
REQ-019 At all times with en=1 the active-level line count SHALL be exactly one; with en=0 it SHALL be zero.
REQ-020 The output SHALL be free of X for any known en/sel.

Reset
REQ-021 rst_n low SHALL immediately (asynchronously) force out to the inactive vector (16'h0000 when ACTIVE_HIGH=1, 16'hFFFF when ACTIVE_HIGH=0) and out_valid to 0.
REQ-022 While rst_n is low, the outputs SHALL hold the inactive values regardless of clk, en and sel.
REQ-023 After rst_n deasserts, the first rising clk edge SHALL load the decode of the current en/sel.
REQ-024 Reset asserted mid-operation SHALL discard the registered decode with no further effect.

Verification
REQ-025 en=0, sweep sel 0..31 (sel[3:0] = 0..15 twice) -> out=16'h0000 and out_valid=0 throughout.
REQ-026 en=1, sweep sel 0..15, one per cycle (OUT_REG=1) -> one cycle later out = 1<<sel, out_valid=1, popcount 1.
REQ-027 en=1, sel=4'hF, then rst_n pulsed low between edges -> out drops to 16'h0000 immediately without a clock edge; after release, the next edge gives out=16'h8000.
REQ-028 OUT_REG=0, en=1, sel=4'h5 -> out=16'h0020 with no clock; en->0 -> out=16'h0000.
REQ-029 ACTIVE_HIGH=0, en=1, sel=4'h3 -> out=16'hFFF7; en=0 -> out=16'hFFFF.
REQ-030 sel toggled 2->9->2 between edges with en=1 -> out changes only at the edge, to the sel value sampled there (16'h0004).
